// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a word on LOAD/RDY, shifts it
// out one bit per enabled clock with FRAME on the first bit and a DONE pulse.
module piso_shift_tx #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         CLK,
    input  logic         res,
    input  logic [N-1:0] D,
    input  logic         LOAD,
    input  logic         EN,
    output logic         RDY,
    output logic         SDO,
    output logic         SVALID,
    output logic         FRAME,
    output logic         DONE
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t        state;
    logic [N-1:0]  shreg;
    logic [N-1:0]  shreg_next;
    logic [CW-1:0] cnt;

    // The bit about to go out always sits at the leading end of the register.
    always_comb begin
        shreg_next = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    end

    always_ff @(posedge CLK) begin
        if (res) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            cnt    <= '0;
            SDO    <= 1'b0;
            SVALID <= 1'b0;
            FRAME  <= 1'b0;
            DONE   <= 1'b0;
            RDY    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (LOAD && RDY) begin
                        shreg  <= D;
                        SDO    <= MSB_FIRST ? D[N-1] : D[0];
                        SVALID <= 1'b1;
                        FRAME  <= 1'b1;
                        cnt    <= '0;
                        RDY    <= 1'b0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (EN) begin
                        FRAME <= 1'b0;
                        if (cnt == LAST) begin
                            SVALID <= 1'b0;
                            SDO    <= 1'b0;
                            DONE   <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            shreg <= shreg_next;
                            SDO   <= MSB_FIRST ? shreg_next[N-1] : shreg_next[0];
                        end
                    end
                end
                ST_DONE: begin
                    DONE  <= 1'b0;
                    RDY   <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
